// File: rtl/hilihase_cmd_responder.sv
// rtl/hilihase_cmd_responder.sv - host-link command responder with CLOSED/OPEN session FSM and response FIFO
module hilihase_cmd_responder #(
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_arg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  output logic              session_open,
  output logic [CNT_W-1:0]  txn_count
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_C = RSP_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TXN_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_INIT  = 3'd1;
  localparam logic [2:0] OP_CLOSE = 3'd2;
  localparam logic [2:0] OP_ECHO1 = 3'd3;
  localparam logic [2:0] OP_ECHO2 = 3'd4;

  localparam logic [1:0] ST_OK         = 2'd0;
  localparam logic [1:0] ST_ERR_STATE  = 2'd1;
  localparam logic [1:0] ST_ERR_OPCODE = 2'd2;

  typedef enum logic {S_CLOSED, S_OPEN} state_t;

  state_t            state, nxt_state;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  nxt_txn;
  logic [1:0]        res_status;
  logic [DATA_W-1:0] res_data;
  logic              push, pop;

  logic [1:0]        st_mem   [RSP_DEPTH];
  logic [DATA_W-1:0] data_mem [RSP_DEPTH];

  // Counter widened on the left so it either zero-extends or truncates into DATA_W.
  logic [DATA_W+CNT_W-1:0] txn_wide;
  assign txn_wide = {{DATA_W{1'b0}}, txn_count};

  assign cmd_ready    = (count < DEPTH_C);
  assign rsp_valid    = (count != '0);
  assign push         = cmd_valid && cmd_ready;
  assign pop          = rsp_valid && rsp_ready;
  assign session_open = (state == S_OPEN);
  assign rsp_status   = rsp_valid ? st_mem[rd_ptr]   : ST_OK;
  assign rsp_data     = rsp_valid ? data_mem[rd_ptr] : '0;

  always_comb begin
    nxt_state  = state;
    nxt_txn    = txn_count;
    res_status = ST_OK;
    res_data   = '0;
    case (cmd_op)
      OP_INIT: begin
        if (state == S_CLOSED) begin
          nxt_state = S_OPEN;
          nxt_txn   = '0;
          res_data  = cmd_arg;
        end else begin
          res_status = ST_ERR_STATE;
        end
      end
      OP_CLOSE: begin
        if (state == S_OPEN) begin
          nxt_state = S_CLOSED;
          nxt_txn   = '0;
          res_data  = txn_wide[DATA_W-1:0];
        end else begin
          res_status = ST_ERR_STATE;
        end
      end
      OP_ECHO1: res_data = cmd_arg;
      OP_ECHO2: begin
        if (state == S_OPEN) begin
          res_data = cmd_arg << 1;
          if (txn_count != '1) nxt_txn = txn_count + TXN_ONE;
        end else begin
          res_status = ST_ERR_STATE;
        end
      end
      default: res_status = ST_ERR_OPCODE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLOSED;
      txn_count <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (push) begin
        state     <= nxt_state;
        txn_count <= nxt_txn;
        wr_ptr    <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      st_mem[wr_ptr]   <= res_status;
      data_mem[wr_ptr] <= res_data;
    end
  end

endmodule

// File: tb/tb_hilihase_cmd_responder.sv
// tb/tb_hilihase_cmd_responder.sv - randomized self-checking bench against a queue-based session model
module tb_hilihase_cmd_responder;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = 3'd0;
  logic [DATA_W-1:0] cmd_arg = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_status;
  logic [DATA_W-1:0] rsp_data;
  logic              session_open;
  logic [CNT_W-1:0]  txn_count;

  hilihase_cmd_responder #(.DATA_W(DATA_W), .RSP_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .session_open(session_open), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected responses as {status, data}, session flag, counter.
  logic [33:0]       m_q[$];
  bit                m_open;
  int                m_cnt;
  bit                m_acc;
  logic [DATA_W-1:0] dut_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_open = 0;
    m_cnt  = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_q.size() > 0));
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(m_q.size() < DEPTH));
    check({tag, ".session_open"}, 32'(session_open), 32'(m_open));
    check({tag, ".txn_count"}, 32'(txn_count), m_cnt);
    if (m_q.size() > 0) begin
      check({tag, ".rsp_status"}, 32'(rsp_status), 32'(m_q[0][33:32]));
      check({tag, ".rsp_data"}, rsp_data, m_q[0][31:0]);
    end
  endtask

  // One cycle: drive at the falling edge, advance the model, check at the next falling edge.
  task automatic step(input bit v, input logic [2:0] op, input logic [31:0] arg, input bit rr);
    int st;
    int dat;
    cmd_valid = v;
    cmd_op    = op;
    cmd_arg   = arg;
    rsp_ready = rr;
    #1;
    if (rsp_valid && rr) dut_log.push_back(rsp_data);
    m_acc = v && (m_q.size() < DEPTH);
    if (rr && m_q.size() > 0) void'(m_q.pop_front());
    if (m_acc) begin
      st = 0;
      dat = 0;
      if (op == 1) begin
        if (!m_open) begin m_open = 1; m_cnt = 0; dat = arg; end else st = 1;
      end else if (op == 2) begin
        if (m_open) begin m_open = 0; dat = m_cnt; m_cnt = 0; end else st = 1;
      end else if (op == 3) begin
        dat = arg;
      end else if (op == 4) begin
        if (m_open) begin
          dat = arg * 2;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else st = 1;
      end else begin
        st = 2;
      end
      m_q.push_back({st[1:0], dat[31:0]});
    end
    @(posedge clk);
    @(negedge clk);
    check_all("cycle");
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.rsp_valid", 32'(rsp_valid), 0);
    check("reset.rsp_status", 32'(rsp_status), 0);
    check("reset.rsp_data", rsp_data, 0);
    check("reset.session_open", 32'(session_open), 0);
    check("reset.cmd_ready", 32'(cmd_ready), 1);
    check("reset.txn_count", 32'(txn_count), 0);
    rst = 1'b0;

    // ECHO1 straight after reset
    step(1, 3, 42, 1);
    check("echo1.valid", 32'(rsp_valid), 1);
    check("echo1.data", rsp_data, 42);
    check("echo1.open", 32'(session_open), 0);
    step(0, 0, 0, 1);

    // INIT / ECHO2 / CLOSE back to back
    step(1, 1, 2, 1);
    check("init.data", rsp_data, 2);
    step(1, 4, 84, 1);
    check("echo2.data", rsp_data, 168);
    check("echo2.txn", 32'(txn_count), 1);
    step(1, 2, 0, 1);
    check("close.data", rsp_data, 1);
    check("close.open", 32'(session_open), 0);
    check("close.txn", 32'(txn_count), 0);
    step(0, 0, 0, 1);

    // Error paths
    step(1, 4, 5, 1);
    check("echo2_closed.status", 32'(rsp_status), 1);
    step(1, 1, 77, 1);
    check("init1.data", rsp_data, 77);
    step(1, 1, 78, 1);
    check("init2.status", 32'(rsp_status), 1);
    step(1, 7, 99, 1);
    check("illegal.status", 32'(rsp_status), 2);
    check("illegal.data", rsp_data, 0);
    step(1, 2, 0, 1);
    step(0, 0, 0, 1);

    // Backpressure: fill, stall fifth, then drain in order
    dut_log.delete();
    for (int i = 1; i <= 4; i++) step(1, 3, i, 0);
    check("bp.cmd_ready_full", 32'(cmd_ready), 0);
    step(1, 3, 5, 0);
    check("bp.fifth_stalled", 32'(m_acc), 0);
    guard = 0;
    m_acc = 0;
    while (!m_acc && guard < 10) begin step(1, 3, 5, 1); guard++; end
    check("bp.fifth_accepted", 32'(m_acc), 1);
    guard = 0;
    while (rsp_valid && guard < 10) begin step(0, 0, 0, 1); guard++; end
    check("bp.drained", 32'(rsp_valid), 0);
    check("bp.count", dut_log.size(), 5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++) check("bp.order", dut_log[i], i + 1);

    // Counter saturation
    step(1, 1, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 4, i, 1);
    check("sat.txn", 32'(txn_count), 15);
    step(1, 2, 0, 1);
    check("sat.close_data", rsp_data, 15);
    step(0, 0, 0, 1);

    // Reset mid-operation with queued responses
    step(1, 1, 3, 0);
    step(1, 3, 4, 0);
    step(1, 3, 5, 0);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_arg = 32'd66;
    rst = 1'b1;
    #1;
    check("rst.rsp_valid", 32'(rsp_valid), 0);
    check("rst.open", 32'(session_open), 0);
    check("rst.txn", 32'(txn_count), 0);
    model_reset();
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    check_all("post_rst");
    step(1, 3, 9, 1);
    check("post_rst.status", 32'(rsp_status), 0);
    check("post_rst.data", rsp_data, 9);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      step($urandom_range(0, 3) != 0, op, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
